// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, waits WAIT_CYCLES for memory, presents the word to decode.
// Define IFETCH_FAULT_DETECT_EN to flag fetches that return FAULT_PATTERN on fetch_fault.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0004,
    parameter int unsigned WAIT_CYCLES   = 2,
    parameter logic [31:0] FAULT_PATTERN = 32'h1234_abcd
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

`ifdef IFETCH_FAULT_DETECT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic {
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pc;
    logic        fault_hit;

    assign imem_addr = pc;
    assign fault_hit = FAULT_EN && (imem_data == FAULT_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_WAIT;
            cnt         <= '0;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (redirect) begin
            // Wins over a simultaneous handshake: the word is consumed, but pc goes to the target.
            state       <= S_WAIT;
            cnt         <= '0;
            pc          <= {redirect_pc[31:2], 2'b00};
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (!halt) begin
                        if (cnt == LAST_CNT) begin
                            instr       <= imem_data;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            fetch_fault <= fault_hit;
                            cnt         <= '0;
                            state       <= S_HOLD;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, hand sequences, random traffic vs a model.
module tb_ifetch_unit;

    localparam int unsigned WC    = 2;
    localparam logic [31:0] FAULT = 32'h1234_abcd;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(
        .RESET_PC      (32'h0000_0004),
        .WAIT_CYCLES   (WC),
        .FAULT_PATTERN (FAULT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image; addresses outside it return an address-derived word.
    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h00: img = 32'h8c01_0000;
            32'h04: img = 32'h0063_0820;
            32'h08: img = 32'h00a4_2822;
            32'h0C: img = 32'h1000_0002;
            32'h10: img = 32'hac05_0008;
            32'h14: img = 32'h0800_0001;
            32'h18: img = FAULT;
            32'h1C: img = 32'h0000_000d;
            default: img = a ^ 32'h5a5a_0f0f;
        endcase
    endfunction

    assign imem_data = img(imem_addr);

    // Reference model: fetch progress measured as non-halted cycles spent waiting on the current pc.
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_fault;
    int          m_waited;

    function automatic void model_reset();
        m_pc = 32'h4; m_instr = '0; m_ipc = '0;
        m_valid = 1'b0; m_fault = 1'b0; m_waited = 0;
    endfunction

    function automatic void model_step();
        if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_fault = 1'b0; m_waited = 0;
        end else if (m_valid) begin
            if (instr_ready) begin
                m_pc = m_pc + 32'd4;
                m_valid = 1'b0; m_waited = 0;
            end
        end else if (!halt) begin
            m_waited++;
            if (m_waited == WC) begin
                m_instr = img(m_pc);
                m_ipc = m_pc;
                m_valid = 1'b1;
                m_waited = 0;
`ifdef IFETCH_FAULT_DETECT_EN
                m_fault = (m_instr == FAULT);
`else
                m_fault = 1'b0;
`endif
            end
        end
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic        halt;
        logic        redir;
        logic        ready;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[17];

`ifdef IFETCH_FAULT_DETECT_EN
    localparam logic EXP_FAULT_18 = 1'b1;
`else
    localparam logic EXP_FAULT_18 = 1'b0;
`endif

    initial begin
        vecs[0]  = '{0, 0, 1, 0,     32'h04, 0, 0,     0};
        vecs[1]  = '{0, 0, 1, 0,     32'h04, 1, 32'h04, 32'h0063_0820};
        vecs[2]  = '{0, 0, 1, 0,     32'h08, 0, 0,     0};
        vecs[3]  = '{0, 0, 0, 0,     32'h08, 0, 0,     0};
        vecs[4]  = '{0, 0, 0, 0,     32'h08, 1, 32'h08, 32'h00a4_2822};
        vecs[5]  = '{0, 0, 0, 0,     32'h08, 1, 32'h08, 32'h00a4_2822};
        vecs[6]  = '{0, 0, 0, 0,     32'h08, 1, 32'h08, 32'h00a4_2822};
        vecs[7]  = '{0, 0, 0, 0,     32'h08, 1, 32'h08, 32'h00a4_2822};
        vecs[8]  = '{1, 0, 0, 0,     32'h08, 1, 32'h08, 32'h00a4_2822};
        vecs[9]  = '{0, 0, 1, 0,     32'h0C, 0, 0,     0};
        vecs[10] = '{0, 1, 0, 32'h13, 32'h10, 0, 0,     0};
        vecs[11] = '{0, 0, 0, 0,     32'h10, 0, 0,     0};
        vecs[12] = '{0, 0, 0, 0,     32'h10, 1, 32'h10, 32'hac05_0008};
        vecs[13] = '{0, 1, 1, 32'h0C, 32'h0C, 0, 0,     0};
        vecs[14] = '{0, 0, 1, 0,     32'h0C, 0, 0,     0};
        vecs[15] = '{0, 0, 1, 0,     32'h0C, 1, 32'h0C, 32'h1000_0002};
        vecs[16] = '{0, 0, 1, 0,     32'h10, 0, 0,     0};

        rst_n = 1'b0; instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        #12;
        chk("reset imem_addr", imem_addr, 32'h4);
        chk("reset instr_valid", 32'(instr_valid), 32'h0);
        chk("reset instr", instr, 32'h0);
        chk("reset instr_pc", instr_pc, 32'h0);
        chk("reset fetch_fault", 32'(fetch_fault), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            halt = vecs[i].halt; redirect = vecs[i].redir;
            instr_ready = vecs[i].ready; redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
                chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
            end
        end

        // PC wrap at the top of the address space.
        halt = 1'b0; instr_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("wrap target", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wrap capture pc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        tick();
        chk("wrap next addr", imem_addr, 32'h0);

        // Fault-pattern word, then halt held in WAIT.
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h18;
        tick();
        redirect = 1'b0;
        tick(); tick();
        chk("fault word", instr, FAULT);
        chk("fault flag", 32'(fetch_fault), 32'(EXP_FAULT_18));
        tick(); tick();
        chk("fault flag held", 32'(fetch_fault), 32'(EXP_FAULT_18));
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h1C;
        tick();
        redirect = 1'b0;
        chk("fault cleared by redirect", 32'(fetch_fault), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt no capture", 32'(instr_valid), 32'h0);
        end
        halt = 1'b0;
        tick();
        chk("halt release wait", 32'(instr_valid), 32'h0);
        tick();
        chk("post-halt capture pc", instr_pc, 32'h1C);

        // Asynchronous reset in the middle of a wait.
        instr_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        chk("midwait reset addr", imem_addr, 32'h4);
        @(posedge clk); #1;
        rst_n = 1'b1;
        compare_all();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            instr_ready = ($urandom_range(0, 1) == 1);
            halt = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = $urandom;
            else
                redirect_pc = $urandom_range(0, 63);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
